// File: rtl/mult_reg_sequencer_if.sv
// Operand-in / product-out handshake bundle for mult_reg_sequencer.
// master = producer/consumer side, slave = the sequencer.
interface mult_reg_sequencer_if #(
   parameter int N = 32
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_a;
   logic [N-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] out_product;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product
   );
endinterface

// File: rtl/mult_reg_sequencer.sv
// Sequences operand-register writes/reads, a fixed-latency multiply window and
// result-register write/read, then presents the captured product on a valid/ready port.
module mult_reg_sequencer #(
   parameter int N       = 32,
   parameter int LATENCY = 4
) (
   input  logic                clk,
   input  logic                reset,
   mult_reg_sequencer_if.slave bus,
   output logic [N-1:0]        op_wdata_a,
   output logic [N-1:0]        op_wdata_b,
   output logic                op_we,
   output logic                op_re,
   output logic                res_we,
   output logic                res_re,
   input  logic [2*N-1:0]      res_rdata,
   output logic                busy
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE_OPS,
      ST_READ_OPS,
      ST_COMPUTE,
      ST_RES_WRITE,
      ST_RES_READ,
      ST_RES_WAIT,
      ST_OUTPUT
   } state_t;

   state_t         state;
   logic [7:0]     cnt;
   logic           ready_q;
   logic           valid_q;
   logic [2*N-1:0] product_q;

   // in_ready is masked by reset so it drops in the same cycle reset rises
   assign bus.in_ready    = ready_q & ~reset;
   assign bus.out_valid   = valid_q;
   assign bus.out_product = product_q;

   // All outputs are registered: each is set on the edge entering the state that owns it
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         op_wdata_a <= '0;
         op_wdata_b <= '0;
         product_q  <= '0;
         op_we      <= 1'b0;
         op_re      <= 1'b0;
         res_we     <= 1'b0;
         res_re     <= 1'b0;
         valid_q    <= 1'b0;
         busy       <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         op_we  <= 1'b0;
         op_re  <= 1'b0;
         res_we <= 1'b0;
         res_re <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op_wdata_a <= bus.in_a;
                  op_wdata_b <= bus.in_b;
                  op_we      <= 1'b1;
                  busy       <= 1'b1;
                  ready_q    <= 1'b0;
                  state      <= ST_WRITE_OPS;
               end
            end
            ST_WRITE_OPS: begin
               op_re <= 1'b1;
               state <= ST_READ_OPS;
            end
            ST_READ_OPS: begin
               cnt   <= 8'(LATENCY - 1);
               state <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               if (cnt == 8'd0) begin
                  res_we <= 1'b1;
                  state  <= ST_RES_WRITE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ST_RES_WRITE: begin
               res_re <= 1'b1;
               state  <= ST_RES_READ;
            end
            ST_RES_READ: begin
               state <= ST_RES_WAIT;
            end
            ST_RES_WAIT: begin
               product_q <= res_rdata;
               valid_q   <= 1'b1;
               state     <= ST_OUTPUT;
            end
            ST_OUTPUT: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  busy    <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/mult_reg_sequencer.md
MULT_REG_SEQUENCER -- requirements
Module: mult_reg_sequencer

Interface
REQ-001 The block SHALL provide parameter N, default 32, the operand width in bits.
REQ-002 The block SHALL provide parameter LATENCY, default 4, the multiplier compute cycles; legal range 1..255.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  the operand pair on in_a/in_b is valid.
REQ-007 in_ready  output  1  the block can accept an operand pair.
REQ-008 in_a  input  N  operand A.
REQ-009 in_b  input  N  operand B.
REQ-010 op_wdata_a  output  N  write data to operand-A register.
REQ-011 op_wdata_b  output  N  write data to operand-B register.
REQ-012 op_we  output  1  write-enable to both operand registers.
REQ-013 op_re  output  1  read-enable to both operand registers (loads their dataOut).
REQ-014 res_we  output  1  write-enable to the result register (captures multiplier output).
REQ-015 res_re  output  1  read-enable to the result register.
REQ-016 res_rdata  input  2N  result register dataOut.
REQ-017 out_valid  output  1  out_product holds a completed product.
REQ-018 out_ready  input  1  consumer accepts out_product.
REQ-019 out_product  output  2N  captured product.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, WRITE_OPS, READ_OPS, COMPUTE, RES_WRITE, RES_READ, RES_WAIT and OUTPUT.
REQ-022 IDLE: in_ready=1; on in_valid&in_ready, in_a/in_b latched into op_wdata_a/op_wdata_b; next state WRITE_OPS.
REQ-023 WRITE_OPS: op_we=1 for exactly one cycle; next state READ_OPS.
REQ-024 READ_OPS: op_re=1 for exactly one cycle; the cycle counter is loaded with LATENCY-1; next state COMPUTE.
REQ-025 COMPUTE: the counter decrements each cycle; when the counter is 0, next state RES_WRITE; residency is exactly LATENCY cycles.
REQ-026 RES_WRITE: res_we=1 for one cycle; next state RES_READ.
REQ-027 RES_READ: res_re=1 for one cycle; next state RES_WAIT.
REQ-028 RES_WAIT: res_rdata is sampled into out_product at the closing edge; next state OPS OUTPUT.
REQ-029 OUTPUT: out_valid=1; out_product held stable; on out_ready, next state IDLE; otherwise stay in OUTPUT indefinitely.
REQ-030 op_we, op_re, res_we and res_re SHALL be mutually exclusive and SHALL never be asserted together.
REQ-031 out_valid SHALL first rise LATENCY+5 clock edges after the accepting edge (9 at default).
REQ-032 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored; no input buffering.
REQ-033 op_wdata_a/op_wdata_b SHALL hold the latched operands from the accept edge until the next accept.
REQ-034 Back-to-back operation: the out_ready handshake returns to IDLE; the next pair is accepted no earlier than the following cycle.
REQ-035 out_product SHALL be 2N bits, stored unmodified from res_rdata, with no truncation or sign handling.

Reset
REQ-036 While reset=1 at a rising edge: state to IDLE, counter to 0, op_wdata_a/op_wdata_b/out_product to 0.
REQ-037 During that reset edge and in the following cycle, all enables, out_valid and busy SHALL be 0.
REQ-038 in_ready SHALL be forced to 0 while reset=1 and SHALL be 1 in the first cycle after reset is released.
REQ-039 Reset in any state, including mid-COMPUTE or OUTPUT, SHALL abandon the operation; no further enable pulses are issued.

Verification
REQ-040 Single op, LATENCY=4: accept a=3,b=5; the bench models the registers and multiplier -> enable pulse sequence op_we, op_re, 4 idle cycles, res_we, res_re; out_valid at edge 9 with out_product=15.
REQ-041 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, out_product constant, in_ready 0, no enable pulses.
REQ-042 Back-to-back: a=0xFFFFFFFF,b=0xFFFFFFFF, then a=7,b=6 with in_valid held high -> products 0xFFFFFFFE00000001 then 42; the second accept occurs after OUTPUT returns to IDLE.
REQ-043 Reset mid-COMPUTE (cycle 4 after accept) -> the next cycle has all outputs 0, busy=0, in_ready=1; no res_we is ever issued for the aborted op.
REQ-044 LATENCY=1 build: accept a=2,b=2 -> out_valid at edge 6, out_product=4.
REQ-045 A bench assertion SHALL check REQ-030 mutual exclusion on every cycle of all scenarios.
